// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, condition codes, flag indices and flag-update masks
package cpu_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_RED    = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_SLL    = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_SRA    = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_ROR    = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_PADDSB = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_LW     = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_SW     = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_LHB    = 4'd10;

  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [2:0] {
    CC_NE  = 3'b000,
    CC_EQ  = 3'b001,
    CC_GT  = 3'b010,
    CC_LT  = 3'b011,
    CC_GE  = 3'b100,
    CC_LE  = 3'b101,
    CC_OV  = 3'b110,
    CC_UNC = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

  // Mask bit positions follow the {Z,V,N} layout of the flag register.
  function automatic logic [2:0] flag_mask(input logic [OPCODE_W-1:0] opcode);
    logic [2:0] m;
    m = 3'b000;
    case (opcode)
      OP_ADD, OP_SUB:          m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA,
      OP_ROR:                  m = 3'b100;
      default:                 m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch condition evaluation against the {Z,V,N} flags
module cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign n = flags[FLG_N];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | ~n;
      CC_LE:   taken = z | n;
      CC_OV:   taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_ctrl.sv
// rtl/flag_branch_ctrl.sv - Z/V/N flag register, branch hazard stall and resolution
module flag_branch_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter int CC_W      = 3,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [OPC_W-1:0] ex_opcode,
  input  logic             ex_stall,
  input  logic             ex_flush,
  input  logic             alu_zero,
  input  logic             alu_ovfl,
  input  logic             alu_neg,
  input  logic             alu_flag_wr,
  input  logic             id_br_valid,
  input  logic [CC_W-1:0]  id_cond,
  output logic [2:0]       flags_q,
  output logic             br_stall,
  output logic             br_resolve,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             flag_err,
  output logic             hazard_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 1) + 1;

  logic [2:0]       mask;
  logic [2:0]       alu_flags;
  logic             retire;
  logic             producer;
  logic             cond_taken;
  br_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;

  assign mask      = flag_mask(ex_opcode);
  assign alu_flags = {alu_zero, alu_ovfl, alu_neg};
  assign retire    = ex_valid & ~ex_stall & ~ex_flush;
  // A stalled producer still blocks the branch: there is no forwarding from EX.
  assign producer  = ex_valid & ~ex_flush & (mask != 3'b000);

  assign br_stall   = id_br_valid & producer;
  assign br_resolve = id_br_valid & ~producer;
  assign br_taken   = br_resolve & cond_taken;

  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (id_cond),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 3'b000;
      flag_err <= 1'b0;
    end else if (retire) begin
      flags_q <= (flags_q & ~mask) | (alu_flags & mask);
      if (alu_flag_wr != (mask != 3'b000)) flag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (br_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      run_q      <= '0;
      hazard_err <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      if (br_stall && (run_q == RUN_W'(MAX_STALL))) hazard_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      ST_IDLE: begin
        if (br_stall) begin
          state_d = ST_WAIT;
          run_d   = RUN_W'(1);
        end
      end
      ST_WAIT: begin
        if (br_stall) begin
          if (run_q != '1) run_d = run_q + RUN_W'(1);
        end else begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// tb/tb_flag_branch_ctrl.sv - directed self-checking bench for flag_branch_ctrl
module tb_flag_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_stall, ex_flush;
  logic [3:0]  ex_opcode;
  logic        alu_zero, alu_ovfl, alu_neg, alu_flag_wr;
  logic        id_br_valid;
  logic [2:0]  id_cond;
  logic [2:0]  flags_q;
  logic        br_stall, br_resolve, br_taken;
  logic [15:0] stall_cnt;
  logic        flag_err, hazard_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flag_branch_ctrl #(
    .OPC_W(4), .CC_W(3), .CNT_W(16), .MAX_STALL(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .alu_zero(alu_zero), .alu_ovfl(alu_ovfl), .alu_neg(alu_neg), .alu_flag_wr(alu_flag_wr),
    .id_br_valid(id_br_valid), .id_cond(id_cond),
    .flags_q(flags_q), .br_stall(br_stall), .br_resolve(br_resolve), .br_taken(br_taken),
    .stall_cnt(stall_cnt), .flag_err(flag_err), .hazard_err(hazard_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [3:0] op, input logic st, input logic fl,
                        input logic [2:0] zvn, input logic fw);
    ex_valid = v; ex_opcode = op; ex_stall = st; ex_flush = fl;
    {alu_zero, alu_ovfl, alu_neg} = zvn; alu_flag_wr = fw;
  endtask

  task automatic set_id(input logic v, input logic [2:0] c);
    id_br_valid = v; id_cond = c;
  endtask

  function automatic logic model_taken(input logic [2:0] f, input logic [2:0] c);
    logic z, v, n;
    {z, v, n} = f;
    case (c)
      3'd0: return ~z;
      3'd1: return z;
      3'd2: return ~z & ~n;
      3'd3: return n;
      3'd4: return z | ~n;
      3'd5: return z | n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    set_id(0, 3'd0);
    tick(); tick();
    chk("rst_flags", 32'(flags_q), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_ferr", 32'(flag_err), 32'h0);
    chk("rst_herr", 32'(hazard_err), 32'h0);
    chk("rst_stall", 32'(br_stall), 32'h0);
    rst_n = 1'b1;
    tick();

    // ADD then XOR flag updates
    set_ex(1, 4'd0, 0, 0, 3'b011, 1);
    tick();
    chk("add_flags", 32'(flags_q), 32'h3);
    set_ex(1, 4'd2, 0, 0, 3'b100, 1);
    tick();
    chk("xor_flags", 32'(flags_q), 32'h7);

    // SUB in EX with EQ branch: one stall cycle then resolve on new Z
    set_ex(1, 4'd1, 0, 0, 3'b100, 1);
    set_id(1, 3'd1);
    #1;
    chk("sub_stall", 32'(br_stall), 32'h1);
    chk("sub_noresolve", 32'(br_resolve), 32'h0);
    chk("sub_taken_gated", 32'(br_taken), 32'h0);
    tick();
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    #1;
    chk("sub_resolve", 32'(br_resolve), 32'h1);
    chk("sub_taken", 32'(br_taken), 32'h1);
    chk("sub_flags", 32'(flags_q), 32'h4);
    chk("sub_cnt", 32'(stall_cnt), 32'h1);
    set_id(0, 3'd0);
    tick();

    // ADD held by ex_stall for 3 cycles, then retires: 4 stall cycles
    set_id(1, 3'd0);
    set_ex(1, 4'd0, 1, 0, 3'b000, 1);
    tick(); tick();
    chk("exst_stall", 32'(br_stall), 32'h1);
    chk("exst_hold", 32'(flags_q), 32'h4);
    tick();
    ex_stall = 1'b0;
    #1;
    chk("exst_last", 32'(br_stall), 32'h1);
    tick();
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    #1;
    chk("exst_cnt", 32'(stall_cnt), 32'h5);
    chk("exst_flags", 32'(flags_q), 32'h0);
    chk("exst_resolve", 32'(br_resolve), 32'h1);
    chk("exst_taken", 32'(br_taken), 32'h1);
    chk("exst_herr", 32'(hazard_err), 32'h0);
    set_id(0, 3'd0);
    tick();

    // Flushed SUB: branch resolves same cycle on old flags
    set_ex(1, 4'd2, 0, 0, 3'b100, 1);
    tick();
    set_ex(1, 4'd1, 0, 1, 3'b011, 1);
    set_id(1, 3'd1);
    #1;
    chk("fl_stall", 32'(br_stall), 32'h0);
    chk("fl_resolve", 32'(br_resolve), 32'h1);
    chk("fl_taken", 32'(br_taken), 32'h1);
    tick();
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    set_id(0, 3'd0);
    #1;
    chk("fl_flags", 32'(flags_q), 32'h4);
    chk("fl_cnt", 32'(stall_cnt), 32'h5);
    chk("fl_ferr", 32'(flag_err), 32'h0);

    // LW retiring with flag write asserted
    set_ex(1, 4'd8, 0, 0, 3'b011, 1);
    tick();
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    chk("lw_ferr", 32'(flag_err), 32'h1);
    chk("lw_flags", 32'(flags_q), 32'h4);
    tick();
    chk("lw_ferr_sticky", 32'(flag_err), 32'h1);

    // Six consecutive stalls trip the watchdog on the fifth
    set_ex(1, 4'd0, 1, 0, 3'b000, 1);
    set_id(1, 3'd7);
    for (int i = 0; i < 4; i++) tick();
    chk("hz_not_yet", 32'(hazard_err), 32'h0);
    tick();
    chk("hz_fifth", 32'(hazard_err), 32'h1);
    tick();
    chk("hz_set", 32'(hazard_err), 32'h1);
    chk("hz_cnt", 32'(stall_cnt), 32'd11);
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    set_id(0, 3'd0);
    tick();

    // Condition sweep: 8 flag values x 8 codes
    for (int f = 0; f < 8; f++) begin
      set_ex(1, 4'd0, 0, 0, 3'(f), 1);
      tick();
      set_ex(0, 4'd0, 0, 0, 3'b000, 0);
      chk("sw_flags", 32'(flags_q), 32'(f));
      for (int c = 0; c < 8; c++) begin
        set_id(1, 3'(c));
        #1;
        chk($sformatf("sw_f%0d_c%0d", f, c), 32'(br_taken), 32'(model_taken(3'(f), 3'(c))));
      end
      set_id(0, 3'd0);
      tick();
    end

    // Asynchronous reset while in WAIT
    set_ex(1, 4'd1, 1, 0, 3'b111, 1);
    set_id(1, 3'd1);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_flags", 32'(flags_q), 32'h0);
    chk("ar_cnt", 32'(stall_cnt), 32'h0);
    chk("ar_ferr", 32'(flag_err), 32'h0);
    chk("ar_herr", 32'(hazard_err), 32'h0);
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    set_id(0, 3'd0);
    #1;
    chk("ar_stall", 32'(br_stall), 32'h0);
    chk("ar_resolve", 32'(br_resolve), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    set_ex(1, 4'd0, 0, 0, 3'b000, 1);
    set_id(1, 3'd1);
    #1;
    chk("ar_restall", 32'(br_stall), 32'h1);
    tick();
    set_ex(0, 4'd0, 0, 0, 3'b000, 0);
    #1;
    chk("ar_recnt", 32'(stall_cnt), 32'h1);
    chk("ar_retaken", 32'(br_taken), 32'h0);
    set_id(0, 3'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
